// File: rtl/cluster_pass_scheduler.sv
// ============================================================================
// cluster_pass_scheduler: per-BX issue of fixed-width cluster encoder passes
// Revision: 1.0
// ============================================================================
`default_nettype none

module cluster_pass_scheduler #(
  parameter  int CNT_W             = 11,
  parameter  int CLUSTERS_PER_PASS = 8,
  parameter  int MAX_PASSES        = 4,
  parameter  int STAT_W            = 16,
  localparam int IDX_W             = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1
) (
  input  logic              clock4x,
  input  logic              reset_n,
  input  logic              bx_strobe_i,
  input  logic              enable_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              pass_ready_i,
  input  logic              clear_stats_i,
  output logic              pass_valid_o,
  output logic [IDX_W-1:0]  pass_idx_o,
  output logic              pass_last_o,
  output logic [CNT_W-1:0]  frame_cnt_o,
  output logic              overflow_o,
  output logic              truncated_o,
  output logic [STAT_W-1:0] ovf_bx_count_o
);

  localparam int SHIFT = $clog2(CLUSTERS_PER_PASS);
  localparam int REM_W = $clog2(MAX_PASSES + 1);
  localparam logic [CNT_W:0] ROUND  = (CNT_W+1)'(CLUSTERS_PER_PASS - 1);
  localparam logic [CNT_W:0] BUDGET = (CNT_W+1)'(MAX_PASSES * CLUSTERS_PER_PASS);
  localparam logic [CNT_W:0] MAXP   = (CNT_W+1)'(MAX_PASSES);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [1:0]        phase_q, phase_d, cur_phase;
  logic              capture;
  logic [CNT_W-1:0]  cnt_eff;
  logic [CNT_W:0]    need;
  logic [REM_W-1:0]  passes;
  logic              ovf_new;
  logic              hs;
  logic [0:0]        state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d, rem_after;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic              ovf_q, ovf_d;
  logic              trunc_q, trunc_d;
  logic [STAT_W-1:0] stat_q, stat_d;

  // A strobe forces the current cycle to phase 0 regardless of the count.
  assign cur_phase = bx_strobe_i ? 2'd0 : phase_q;
  assign phase_d   = cur_phase + 2'd1;
  assign capture   = (cur_phase == 2'd0);

  assign cnt_eff = enable_i ? cnt_i : '0;
  assign need    = ({1'b0, cnt_eff} + ROUND) >> SHIFT;
  assign passes  = (need > MAXP) ? REM_W'(MAX_PASSES) : need[REM_W-1:0];
  assign ovf_new = ({1'b0, cnt_eff} > BUDGET);

  assign hs        = (state_q == S_ISSUE) && pass_ready_i;
  assign rem_after = hs ? (rem_q - REM_W'(1)) : rem_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    ovf_d   = ovf_q;
    trunc_d = 1'b0;
    stat_d  = stat_q;
    if (capture) begin
      // Any handshake this cycle still counts before the new frame replaces state.
      trunc_d = (state_q == S_ISSUE) && (rem_after != '0);
      fcnt_d  = cnt_eff;
      ovf_d   = ovf_new;
      rem_d   = passes;
      idx_d   = '0;
      state_d = (passes != '0) ? S_ISSUE : S_IDLE;
      if (ovf_new && (stat_q != '1)) begin
        stat_d = stat_q + STAT_W'(1);
      end
    end else if (hs) begin
      rem_d = rem_after;
      idx_d = idx_q + IDX_W'(1);
      if (rem_q == REM_W'(1)) begin
        state_d = S_IDLE;
      end
    end
    if (clear_stats_i) begin
      stat_d = '0;
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 2'd0;
      state_q <= S_IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
      stat_q  <= '0;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
      stat_q  <= stat_d;
    end
  end

  assign pass_valid_o   = (state_q == S_ISSUE);
  assign pass_idx_o     = idx_q;
  assign pass_last_o    = (state_q == S_ISSUE) && (rem_q == REM_W'(1));
  assign frame_cnt_o    = fcnt_q;
  assign overflow_o     = ovf_q;
  assign truncated_o    = trunc_q;
  assign ovf_bx_count_o = stat_q;

endmodule

`default_nettype wire

// File: tb/tb_cluster_pass_scheduler.sv
// ============================================================================
// tb_cluster_pass_scheduler: scoreboard bench for cluster_pass_scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cluster_pass_scheduler;

  localparam int CNT_W  = 11;
  localparam int IDX_W  = 2;
  localparam int STAT_W = 16;

  logic              clock4x = 1'b0;
  logic              reset_n = 1'b0;
  logic              bx_strobe_i = 1'b0;
  logic              enable_i = 1'b0;
  logic [CNT_W-1:0]  cnt_i = '0;
  logic              pass_ready_i = 1'b0;
  logic              clear_stats_i = 1'b0;
  logic              pass_valid_o;
  logic [IDX_W-1:0]  pass_idx_o;
  logic              pass_last_o;
  logic [CNT_W-1:0]  frame_cnt_o;
  logic              overflow_o;
  logic              truncated_o;
  logic [STAT_W-1:0] ovf_bx_count_o;

  int checks = 0;
  int errors = 0;
  int exp_stat = 0;
  logic [IDX_W:0] exp_q[$];

  cluster_pass_scheduler #(
    .CNT_W(CNT_W), .CLUSTERS_PER_PASS(8), .MAX_PASSES(4), .STAT_W(STAT_W)
  ) dut (
    .clock4x(clock4x), .reset_n(reset_n), .bx_strobe_i(bx_strobe_i),
    .enable_i(enable_i), .cnt_i(cnt_i), .pass_ready_i(pass_ready_i),
    .clear_stats_i(clear_stats_i), .pass_valid_o(pass_valid_o),
    .pass_idx_o(pass_idx_o), .pass_last_o(pass_last_o),
    .frame_cnt_o(frame_cnt_o), .overflow_o(overflow_o),
    .truncated_o(truncated_o), .ovf_bx_count_o(ovf_bx_count_o)
  );

  always #5 clock4x = ~clock4x;

  // Accepted passes are popped from the scoreboard mid-cycle.
  always @(negedge clock4x) begin
    if (reset_n && pass_valid_o && pass_ready_i) begin
      logic [IDX_W:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_pass: got idx=%0d last=%0d, required no pass", pass_idx_o, pass_last_o);
      end else begin
        e = exp_q.pop_front();
        if ({pass_idx_o, pass_last_o} !== e) begin
          errors++;
          $display("FAIL sb_pass: got idx=%0d last=%0d, required idx=%0d last=%0d",
                   pass_idx_o, pass_last_o, e[IDX_W:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock4x);
    #1;
  endtask

  // Called right after a capture edge: drops unfinished passes, queues the new frame.
  task automatic load_frame(input int cnt, input bit en, output int dropped);
    int n;
    logic [IDX_W-1:0] ix;
    logic lst;
    dropped = exp_q.size();
    exp_q.delete();
    n = en ? (cnt + 7) / 8 : 0;
    if (n > 4) n = 4;
    for (int i = 0; i < n; i++) begin
      ix  = IDX_W'(i);
      lst = (i == n - 1);
      exp_q.push_back({ix, lst});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock4x);
    #1;
    checks++;
    if ({pass_valid_o, pass_idx_o, pass_last_o, frame_cnt_o, overflow_o, truncated_o, ovf_bx_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0d idx=%0d last=%0d fcnt=%0d ovf=%0d trunc=%0d stat=%0d, required all 0",
               pass_valid_o, pass_idx_o, pass_last_o, frame_cnt_o, overflow_o, truncated_o, ovf_bx_count_o);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_normal();
    int d;
    cnt_i = 11'd17; enable_i = 1'b1; pass_ready_i = 1'b1;
    tick();
    load_frame(17, 1'b1, d);
    cnt_i = '0;
    checks++;
    if (d != 0) begin errors++; $display("FAIL normal_dropped: got %0d required 0", d); end
    checks++;
    if (frame_cnt_o !== 11'd17) begin errors++; $display("FAIL normal_fcnt: got %0d required 17", frame_cnt_o); end
    checks++;
    if (overflow_o !== 1'b0 || truncated_o !== 1'b0) begin
      errors++; $display("FAIL normal_flags: got ovf=%0d trunc=%0d required 0 0", overflow_o, truncated_o);
    end
    checks++;
    if (pass_valid_o !== 1'b1 || pass_idx_o !== 2'd0) begin
      errors++; $display("FAIL normal_first_req: got valid=%0d idx=%0d required 1 0", pass_valid_o, pass_idx_o);
    end
    repeat (3) tick();
    checks++;
    if (pass_valid_o !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL normal_done: got valid=%0d pending=%0d required 0 0", pass_valid_o, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int d;
    for (int f = 0; f < 4; f++) begin
      cnt_i = 11'd40; enable_i = 1'b1; pass_ready_i = 1'b1;
      tick();
      load_frame(40, 1'b1, d);
      exp_stat++;
      checks++;
      if (d != 0 || truncated_o !== 1'b0) begin
        errors++; $display("FAIL ovf_dropped: got dropped=%0d trunc=%0d required 0 0", d, truncated_o);
      end
      checks++;
      if (overflow_o !== 1'b1 || frame_cnt_o !== 11'd40) begin
        errors++; $display("FAIL ovf_frame: got ovf=%0d fcnt=%0d required 1 40", overflow_o, frame_cnt_o);
      end
      checks++;
      if (ovf_bx_count_o !== STAT_W'(exp_stat)) begin
        errors++; $display("FAIL ovf_stat: got %0d required %0d", ovf_bx_count_o, exp_stat);
      end
      repeat (3) tick();
    end
    checks++;
    if (pass_valid_o !== 1'b1 || pass_idx_o !== 2'd3 || pass_last_o !== 1'b1) begin
      errors++; $display("FAIL ovf_slot4: got valid=%0d idx=%0d last=%0d required 1 3 1", pass_valid_o, pass_idx_o, pass_last_o);
    end
  endtask

  task automatic test_backpressure();
    int d;
    cnt_i = 11'd32; pass_ready_i = 1'b1;
    tick();
    load_frame(32, 1'b1, d);
    pass_ready_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0 || frame_cnt_o !== 11'd32) begin
      errors++; $display("FAIL bp_budget_edge: got ovf=%0d fcnt=%0d required 0 32", overflow_o, frame_cnt_o);
    end
    tick();
    checks++;
    if (pass_valid_o !== 1'b1 || pass_idx_o !== 2'd0 || pass_last_o !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got valid=%0d idx=%0d last=%0d required 1 0 0", pass_valid_o, pass_idx_o, pass_last_o);
    end
    tick();
    pass_ready_i = 1'b1;
    tick();
    checks++;
    if (pass_idx_o !== 2'd1 || pass_last_o !== 1'b0) begin
      errors++; $display("FAIL bp_phase0_idx: got idx=%0d last=%0d required 1 0", pass_idx_o, pass_last_o);
    end
    cnt_i = '0;
    tick();
    load_frame(0, 1'b1, d);
    checks++;
    if (d != 2) begin errors++; $display("FAIL bp_accepted: got dropped=%0d required 2", d); end
    checks++;
    if (truncated_o !== 1'b1 || pass_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_trunc: got trunc=%0d valid=%0d required 1 0", truncated_o, pass_valid_o);
    end
    tick();
    checks++;
    if (truncated_o !== 1'b0) begin errors++; $display("FAIL bp_trunc_width: got %0d required 0", truncated_o); end
    repeat (2) tick();
  endtask

  task automatic test_empty_disabled();
    int d;
    cnt_i = '0; enable_i = 1'b1;
    tick();
    load_frame(0, 1'b1, d);
    checks++;
    if (frame_cnt_o !== '0 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL empty_frame: got fcnt=%0d ovf=%0d required 0 0", frame_cnt_o, overflow_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pass_valid_o !== 1'b0) begin errors++; $display("FAIL empty_valid: got %0d required 0", pass_valid_o); end
      tick();
    end
    cnt_i = 11'd100; enable_i = 1'b0;
    tick();
    load_frame(100, 1'b0, d);
    checks++;
    if (frame_cnt_o !== '0 || overflow_o !== 1'b0 || ovf_bx_count_o !== STAT_W'(exp_stat)) begin
      errors++; $display("FAIL disabled_frame: got fcnt=%0d ovf=%0d stat=%0d required 0 0 %0d",
                         frame_cnt_o, overflow_o, ovf_bx_count_o, exp_stat);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pass_valid_o !== 1'b0) begin errors++; $display("FAIL disabled_valid: got %0d required 0", pass_valid_o); end
      tick();
    end
    enable_i = 1'b1;
  endtask

  task automatic test_strobe_resync();
    int d;
    cnt_i = 11'd40; pass_ready_i = 1'b1;
    tick();
    load_frame(40, 1'b1, d);
    exp_stat++;
    tick();
    bx_strobe_i = 1'b1; cnt_i = 11'd17;
    tick();
    bx_strobe_i = 1'b0;
    load_frame(17, 1'b1, d);
    checks++;
    if (d != 2) begin errors++; $display("FAIL strobe_dropped: got %0d required 2", d); end
    checks++;
    if (truncated_o !== 1'b1 || frame_cnt_o !== 11'd17 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL strobe_capture: got trunc=%0d fcnt=%0d ovf=%0d required 1 17 0",
                         truncated_o, frame_cnt_o, overflow_o);
    end
    checks++;
    if (pass_valid_o !== 1'b1 || pass_idx_o !== 2'd0 || ovf_bx_count_o !== STAT_W'(exp_stat)) begin
      errors++; $display("FAIL strobe_req: got valid=%0d idx=%0d stat=%0d required 1 0 %0d",
                         pass_valid_o, pass_idx_o, ovf_bx_count_o, exp_stat);
    end
    tick();
    checks++;
    if (truncated_o !== 1'b0) begin errors++; $display("FAIL strobe_trunc_width: got %0d required 0", truncated_o); end
    repeat (2) tick();
    checks++;
    if (pass_valid_o !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL strobe_done: got valid=%0d pending=%0d required 0 0", pass_valid_o, exp_q.size());
    end
  endtask

  task automatic test_stats_saturate();
    int n;
    n = 65535 - exp_stat;
    pass_ready_i = 1'b0; bx_strobe_i = 1'b1; cnt_i = 11'd40;
    for (int i = 0; i < n; i++) tick();
    checks++;
    if (ovf_bx_count_o !== 16'hFFFF) begin errors++; $display("FAIL stat_reach_max: got %0h required ffff", ovf_bx_count_o); end
    tick();
    checks++;
    if (ovf_bx_count_o !== 16'hFFFF) begin errors++; $display("FAIL stat_saturate: got %0h required ffff", ovf_bx_count_o); end
    clear_stats_i = 1'b1;
    tick();
    checks++;
    if (ovf_bx_count_o !== '0) begin errors++; $display("FAIL stat_clear_vs_inc: got %0h required 0", ovf_bx_count_o); end
    clear_stats_i = 1'b0; cnt_i = '0;
    tick();
    bx_strobe_i = 1'b0;
    exp_stat = 0;
    checks++;
    if (ovf_bx_count_o !== '0 || pass_valid_o !== 1'b0 || truncated_o !== 1'b1) begin
      errors++; $display("FAIL stat_after_clear: got stat=%0h valid=%0d trunc=%0d required 0 0 1",
                         ovf_bx_count_o, pass_valid_o, truncated_o);
    end
    repeat (3) tick();
    pass_ready_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    int d;
    cnt_i = 11'd40; pass_ready_i = 1'b1;
    tick();
    load_frame(40, 1'b1, d);
    tick();
    pass_ready_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pass_valid_o, pass_idx_o, pass_last_o, frame_cnt_o, overflow_o, truncated_o, ovf_bx_count_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%0d idx=%0d last=%0d fcnt=%0d ovf=%0d trunc=%0d stat=%0d, required all 0",
               pass_valid_o, pass_idx_o, pass_last_o, frame_cnt_o, overflow_o, truncated_o, ovf_bx_count_o);
    end
    exp_q.delete();
    @(posedge clock4x);
    #1;
    reset_n = 1'b1;
    cnt_i = 11'd17; pass_ready_i = 1'b1;
    tick();
    load_frame(17, 1'b1, d);
    checks++;
    if (pass_valid_o !== 1'b1 || pass_idx_o !== 2'd0 || frame_cnt_o !== 11'd17 || truncated_o !== 1'b0) begin
      errors++; $display("FAIL reset_first_capture: got valid=%0d idx=%0d fcnt=%0d trunc=%0d required 1 0 17 0",
                         pass_valid_o, pass_idx_o, frame_cnt_o, truncated_o);
    end
    repeat (3) tick();
    checks++;
    if (pass_valid_o !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL reset_frame_done: got valid=%0d pending=%0d required 0 0", pass_valid_o, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_backpressure();
    test_empty_disabled();
    test_strobe_resync();
    test_stats_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cluster_pass_scheduler.md
# cluster_pass_scheduler

Per-bunch-crossing scheduler for the cluster encoder passes that sit behind the 768-strip cluster counter. Runs on clock4x, four cycles per BX. At the start of each BX it samples the cluster count, computes how many fixed-width encoder passes are needed, and issues them to the encoder with a valid/ready handshake. It also flags frames whose clusters exceed the pass budget and keeps a saturating count of overflowed BXs for slow control.

## Interface
- CNT_W, 11, width of the incoming cluster count
- CLUSTERS_PER_PASS, 8, clusters extracted per encoder pass; power of two
- MAX_PASSES, 4, pass slots per BX; power of two, at most 4
- STAT_W, 16, width of the overflow-BX statistics counter

Ports:
- clock4x  in  1  4x LHC clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- bx_strobe_i  in  1  one-cycle pulse marking phase 0 of a BX; resynchronises the phase counter
- enable_i  in  1  scheduler enable; sampled at capture
- cnt_i  in  CNT_W  cluster count, valid in the capture cycle
- pass_ready_i  in  1  encoder accepts a pass this cycle
- clear_stats_i  in  1  synchronous clear of ovf_bx_count_o
- pass_valid_o  out  1  pass request
- pass_idx_o  out  log2(MAX_PASSES)  pass number within the frame, from 0
- pass_last_o  out  1  the current request is the final pass of the frame
- frame_cnt_o  out  CNT_W  count captured for the current frame
- overflow_o  out  1  the current frame exceeds MAX_PASSES*CLUSTERS_PER_PASS clusters
- truncated_o  out  1  one-cycle pulse: passes were dropped at the frame boundary
- ovf_bx_count_o  out  STAT_W  saturating count of frames with overflow_o set

## Operation
- Phase counter: 2 bits.
  - If bx_strobe_i=1, the current cycle is phase 0 and the next phase is 1.
  - Otherwise the phase increments mod 4.
- Capture cycle: any cycle whose phase is 0.
- Capture loads frame_cnt_o with cnt_i, or with 0 when enable_i=0.
- need = ceil(cnt/CLUSTERS_PER_PASS), computed as (cnt + CPP-1) >> log2(CPP) at CNT_W+1 bits so it cannot overflow.
- passes = min(need, MAX_PASSES).
- overflow_o = (captured cnt > MAX_PASSES*CLUSTERS_PER_PASS). It is registered at capture and held for the whole frame.
- FSM has two states.
  - IDLE: pass_valid_o=0. At capture, go to ISSUE with remaining=passes and pass_idx_o=0 if passes>0. Otherwise stay in IDLE.
  - ISSUE: pass_valid_o=1, and pass_last_o=(remaining==1).
  - On handshake (valid & ready): remaining decrements and pass_idx_o increments.
  - When the last pass is accepted, return to IDLE.
  - If ready=0, hold valid, idx and last unchanged.
- Frame boundary (capture while in ISSUE):
  - A handshake in that same cycle is still accepted.
  - If remaining is still >0 after that handshake, pulse truncated_o for one cycle on the next cycle.
  - The new frame always loads, replacing any outstanding state.
- Statistics:
  - ovf_bx_count_o increments by 1 on the cycle after each capture with overflow set, saturating at all-ones.
  - clear_stats_i zeroes it. If a clear and an increment occur in the same cycle, the result is 0.
- enable_i=0 at capture: the frame has frame_cnt=0, no passes and no overflow.

## Timing
- Reset (async assert): all outputs are 0 and the phase is 0. FSM goes to IDLE and the statistics counter to 0.
- The first rising edge after reset_n deasserts is a capture cycle.
- Capture at edge N:
  - frame_cnt_o and overflow_o update at edge N+1.
  - pass_valid_o is high from edge N+1, so the first request is visible in phase 1.
- Pass slots are phases 1, 2, 3 and the next phase 0. With ready held high, MAX_PASSES=4 passes complete within the BX.
- Pass latency: the handshake in cycle k makes the next request visible in cycle k+1. Throughput is one pass per cycle.
- truncated_o is high in phase 1 of the new frame.
- A bx_strobe_i arriving off-phase shortens the current frame at once. The truncation rules apply unchanged.
- Reset asserted mid-frame aborts all requests immediately; no truncated_o pulse is generated.

## Test plan
- Normal frame:
  - Stimulus: cnt_i=17, ready=1.
  - Required: 3 passes in phases 1–3 with idx 0, 1, 2, pass_last_o on idx 2, overflow_o=0, no truncation.
- Overflow:
  - Stimulus: cnt_i=40.
  - Required: 4 passes (idx 0–3), overflow_o=1 for the frame, ovf_bx_count_o goes 0→1. Repeat 3 BXs and the counter reads 4.
- Backpressure and truncation:
  - Stimulus: cnt_i=32, ready low in phases 1–2.
  - Required: only idx 0 and 1 are accepted (in phases 3 and 0), and truncated_o pulses in the next phase 1.
- Empty and disabled frames:
  - Stimulus: cnt_i=0; then cnt_i=100 with enable_i=0.
  - Required: pass_valid_o never rises, frame_cnt_o=0 and overflow_o=0 in both cases.
- Strobe resync and stats:
  - Stimulus: bx_strobe_i in phase 2 during a 4-pass frame.
  - Required: a new capture in that cycle, truncated_o pulses next cycle. Drive the counter to 0xFFFF and confirm it saturates; clear_stats_i gives 0.
- Async reset mid-ISSUE:
  - Stimulus: pulse reset_n low mid-frame.
  - Required: all outputs drop to 0 immediately, and the first edge after release is a capture.
